random_reader: RTL and testbench

//  Consumer end of the LFSR random FIFO. Pops 64-bit words from the FIFO
//  (standard-mode read: read_ack pulse, data plus valid on a later cycle)
//  and serves 1..32-bit random values on demand to the pulse-sequencer

---
 rtl/random_reader.sv | 149 ++++++++++++++
 tb/tb_random_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/random_reader.sv
// Random-word consumer: pops 64-bit words from the LFSR FIFO and serves 1..32-bit slices on demand.
// Optional macro RANDOM_READER_THRESH_EN adds a threshold input and a registered Bernoulli decision output.
module random_reader #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] random,
    input  logic        valid,
    output logic        read_ack,
    input  logic        req,
    input  logic [5:0]  req_bits,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
`ifdef RANDOM_READER_THRESH_EN
    input  logic [31:0] threshold,
    output logic        decision,
`endif
    output logic [31:0] words_consumed
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SERVE} state_t;

    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [5:0]  n_q, n_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0] result_q, result_d;
    logic        resultValid_q, resultValid_d;
    logic [31:0] words_q, words_d;
    logic [5:0]  reqN;
`ifdef RANDOM_READER_THRESH_EN
    logic [31:0] thresh_q, thresh_d;
    logic        decision_q, decision_d;
`endif

    function automatic logic [31:0] lowMask(input logic [5:0] n);
        logic [32:0] m;
        m = (33'd1 << n) - 33'd1;
        return m[31:0];
    endfunction

    assign reqN = (req_bits > 6'd32) ? 6'd32 : req_bits;

    // SERVE has busy low, so it accepts a request exactly like IDLE does.
    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        cnt_d         = cnt_q;
        n_d           = n_q;
        timer_d       = timer_q;
        result_d      = result_q;
        resultValid_d = 1'b0;
        words_d       = words_q;
`ifdef RANDOM_READER_THRESH_EN
        thresh_d      = thresh_q;
        decision_d    = decision_q;
`endif
        case (state_q)
            IDLE, SERVE: begin
                state_d = IDLE;
                if (req) begin
                    if ({1'b0, reqN} <= cnt_q) begin
                        result_d      = buf_q[31:0] & lowMask(reqN);
                        resultValid_d = 1'b1;
                        buf_d         = buf_q >> reqN;
                        cnt_d         = cnt_q - {1'b0, reqN};
`ifdef RANDOM_READER_THRESH_EN
                        decision_d    = (result_d < threshold);
`endif
                    end else begin
                        n_d     = reqN;
                        cnt_d   = 7'd0;
                        state_d = FETCH;
`ifdef RANDOM_READER_THRESH_EN
                        thresh_d = threshold;
`endif
                    end
                end
            end
            FETCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                // The fresh word is sliced here so the result lands in the SERVE cycle.
                if (valid) begin
                    result_d      = random[31:0] & lowMask(n_q);
                    resultValid_d = 1'b1;
                    buf_d         = random >> n_q;
                    cnt_d         = 7'd64 - {1'b0, n_q};
                    words_d       = words_q + 32'd1;
                    state_d       = SERVE;
`ifdef RANDOM_READER_THRESH_EN
                    decision_d    = (result_d < thresh_q);
`endif
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            cnt_q         <= '0;
            n_q           <= '0;
            timer_q       <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            words_q       <= '0;
`ifdef RANDOM_READER_THRESH_EN
            thresh_q      <= '0;
            decision_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            n_q           <= n_d;
            timer_q       <= timer_d;
            result_q      <= result_d;
            resultValid_q <= resultValid_d;
            words_q       <= words_d;
`ifdef RANDOM_READER_THRESH_EN
            thresh_q      <= thresh_d;
            decision_q    <= decision_d;
`endif
        end
    end

    assign read_ack       = (state_q == FETCH);
    assign busy           = (state_q == FETCH) || (state_q == WAIT);
    assign result         = result_q;
    assign result_valid   = resultValid_q;
    assign words_consumed = words_q;
`ifdef RANDOM_READER_THRESH_EN
    assign decision       = decision_q;
`endif

endmodule

// File: tb/tb_random_reader.sv
// Directed bench for random_reader: per-cycle vector table plus timeout, reset-in-WAIT and threshold sequences.
module tb_random_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] random = '0;
    logic        valid = 1'b0;
    logic        read_ack;
    logic        req = 1'b0;
    logic [5:0]  req_bits = '0;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic [31:0] words_consumed;
`ifdef RANDOM_READER_THRESH_EN
    logic [31:0] threshold = '0;
    logic        decision;
`endif

    int errors = 0;
    int checks = 0;

    random_reader #(.TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .random(random),
        .valid(valid),
        .read_ack(read_ack),
        .req(req),
        .req_bits(req_bits),
        .result(result),
        .result_valid(result_valid),
        .busy(busy),
`ifdef RANDOM_READER_THRESH_EN
        .threshold(threshold),
        .decision(decision),
`endif
        .words_consumed(words_consumed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        req;
        logic [5:0]  bits;
        logic        valid;
        logic [63:0] rnd;
        logic        expRa;
        logic        expRv;
        logic [31:0] expRes;
        logic        expBusy;
        logic [31:0] expWc;
    } vec_t;

    vec_t vecs[$];

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic q, input logic [5:0] b, input logic v,
                          input logic [63:0] d, input logic ra, input logic rv,
                          input logic [31:0] res, input logic bz, input logic [31:0] wc);
        vec_t x;
        x.rst = r; x.req = q; x.bits = b; x.valid = v; x.rnd = d;
        x.expRa = ra; x.expRv = rv; x.expRes = res; x.expBusy = bz; x.expWc = wc;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input vec_t x);
        rst = x.rst; req = x.req; req_bits = x.bits; valid = x.valid; random = x.rnd;
        tick();
    endtask

    initial begin
        // rst req bits valid random | read_ack result_valid result busy words
        addVec(1, 0,  0, 0, 64'h0,                   0, 0, 32'h0,        0, 0);
        addVec(0, 1,  8, 0, 64'h0,                   1, 0, 32'h0,        1, 0);
        addVec(0, 0,  0, 0, 64'h0,                   0, 0, 32'h0,        1, 0);
        addVec(0, 0,  0, 1, 64'h0123_4567_89AB_CDEF, 0, 1, 32'hEF,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'hCD,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'hAB,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'h89,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'h67,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'h45,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'h23,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   0, 1, 32'h01,       0, 1);
        addVec(0, 1,  8, 0, 64'h0,                   1, 0, 32'h01,       1, 1);
        addVec(0, 0,  0, 0, 64'h0,                   0, 0, 32'h01,       1, 1);
        addVec(0, 0,  0, 1, 64'hFEDC_BA98_7654_3210, 0, 1, 32'h10,       0, 2);
        addVec(0, 1, 32, 0, 64'h0,                   0, 1, 32'h98765432, 0, 2);
        addVec(0, 1, 16, 0, 64'h0,                   0, 1, 32'hDCBA,     0, 2);
        addVec(0, 1, 16, 0, 64'h0,                   1, 0, 32'hDCBA,     1, 2);
        addVec(0, 0,  0, 0, 64'h0,                   0, 0, 32'hDCBA,     1, 2);
        addVec(0, 0,  0, 1, 64'h1111_2222_3333_ABCD, 0, 1, 32'hABCD,     0, 3);
        addVec(0, 1, 32, 0, 64'h0,                   0, 1, 32'h22223333, 0, 3);
        addVec(0, 1, 16, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 32'h1111,     0, 3);
        addVec(0, 1,  1, 0, 64'h0,                   1, 0, 32'h1111,     1, 3);
        addVec(0, 0,  0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h1111,     1, 3);
        addVec(0, 0,  0, 1, 64'hA5A5_A5A5_F0F0_F0F1, 0, 1, 32'h1,        0, 4);
        addVec(0, 1,  0, 0, 64'h0,                   0, 1, 32'h0,        0, 4);
        addVec(0, 1, 40, 0, 64'h0,                   0, 1, 32'hF8787878, 0, 4);
        addVec(0, 1, 31, 0, 64'h0,                   0, 1, 32'h52D2D2D2, 0, 4);
        addVec(0, 1, 63, 0, 64'h0,                   1, 0, 32'h52D2D2D2, 1, 4);
        addVec(0, 1,  8, 0, 64'h0,                   0, 0, 32'h52D2D2D2, 1, 4);
        addVec(0, 1,  8, 1, 64'h0000_0000_1234_5678, 0, 1, 32'h12345678, 0, 5);
        addVec(0, 0,  0, 0, 64'h0,                   0, 0, 32'h12345678, 0, 5);

        #1;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d read_ack", i), 64'(read_ack), 64'(vecs[i].expRa));
            checkOutput($sformatf("v%0d result_valid", i), 64'(result_valid), 64'(vecs[i].expRv));
            checkOutput($sformatf("v%0d result", i), 64'(result), 64'(vecs[i].expRes));
            checkOutput($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].expBusy));
            checkOutput($sformatf("v%0d words", i), 64'(words_consumed), 64'(vecs[i].expWc));
        end

        // Empty FIFO: retry read_ack every TIMEOUT+1 cycles with busy held high.
        rst = 1'b1; req = 1'b0; valid = 1'b0;
        tick();
        rst = 1'b0; req = 1'b1; req_bits = 6'd8;
        tick();
        req = 1'b0;
        for (int i = 1; i <= 29; i++) begin
            if (i > 1) tick();
            checkOutput($sformatf("timeout c%0d read_ack", i), 64'(read_ack), 64'(((i - 1) % 9) == 0));
            checkOutput($sformatf("timeout c%0d busy", i), 64'(busy), 64'd1);
        end
        valid = 1'b1; random = 64'h0000_0000_0000_005A;
        tick();
        valid = 1'b0;
        checkOutput("timeout late result_valid", 64'(result_valid), 64'd1);
        checkOutput("timeout late result", 64'(result), 64'h5A);
        checkOutput("timeout late words", 64'(words_consumed), 64'd1);
        checkOutput("timeout late busy", 64'(busy), 64'd0);

        // Reset while waiting, then a late valid that must be ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0; req = 1'b1; req_bits = 6'd8;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; valid = 1'b1; random = 64'h0000_0000_0000_00C3;
        tick();
        valid = 1'b0;
        checkOutput("rstwait words", 64'(words_consumed), 64'd0);
        checkOutput("rstwait result_valid", 64'(result_valid), 64'd0);
        checkOutput("rstwait busy", 64'(busy), 64'd0);
        checkOutput("rstwait read_ack", 64'(read_ack), 64'd0);
        tick();
        checkOutput("rstwait result", 64'(result), 64'd0);
        checkOutput("rstwait words later", 64'(words_consumed), 64'd0);

`ifdef RANDOM_READER_THRESH_EN
        threshold = 32'h80; req = 1'b1; req_bits = 6'd8;
        tick();
        req = 1'b0;
        tick();
        valid = 1'b1; random = 64'h0000_0000_0000_807F;
        tick();
        valid = 1'b0;
        checkOutput("thresh 7F result", 64'(result), 64'h7F);
        checkOutput("thresh 7F decision", 64'(decision), 64'd1);
        req = 1'b1; req_bits = 6'd8;
        tick();
        req = 1'b0;
        checkOutput("thresh 80 result", 64'(result), 64'h80);
        checkOutput("thresh 80 decision", 64'(decision), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
